// File: rtl/wrr_last_rank_tracker.sv
// Dequeue-side last-rank tracker: keeps the newest dequeued PIFO word per port plus dequeue/stale counters.
// Optional macro WRR_LAST_RANK_STALE_FILTER_EN enables the epoch-based stale-event filter.
module wrr_last_rank_tracker #(
  parameter int NUM_PORTS = 5,
  parameter int CNT_W     = 16
) (
  input  logic        clk_dp,
  input  logic        rst_n,
  input  logic        deq_valid,
  input  logic [7:0]  deq_port,
  input  logic [31:0] deq_rank,
  output logic [31:0] wire_out_last_pkt_info0,
  output logic [31:0] wire_out_last_pkt_info1,
  output logic [31:0] wire_out_last_pkt_info2,
  output logic [31:0] wire_out_last_pkt_info3,
  output logic [31:0] wire_out_last_pkt_info4,
  input  logic        cp_rd_valid,
  input  logic [2:0]  cp_rd_port,
  output logic        cp_rd_valid_out,
  output logic [31:0] cp_rd_data,
  output logic        err_port
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        port_onehot;
  logic [2:0]  port_idx;
  logic        s1_valid_reg;
  logic [2:0]  s1_port_reg;
  logic [31:0] s1_word_reg;

  logic [NUM_PORTS-1:0][31:0]    info_vec;
  logic [NUM_PORTS-1:0][CNT_W-1:0] deq_cnt_vec;
  logic [NUM_PORTS-1:0][CNT_W-1:0] stale_cnt_vec;
  logic [31:0] rd_word;

  // Exactly one bit set, and it must fall inside the tracked port range.
  assign port_onehot = (deq_port != 8'd0) &&
                       ((deq_port & (deq_port - 8'd1)) == 8'd0) &&
                       (deq_port[7:5] == 3'd0);

  always_comb begin
    port_idx = 3'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (deq_port[i]) port_idx = 3'(i);
    end
  end

  // Stage 1: validate and decode the dequeue event.
  always_ff @(posedge clk_dp) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_port_reg  <= 3'd0;
      s1_word_reg  <= 32'd0;
      err_port     <= 1'b0;
    end else begin
      s1_valid_reg <= deq_valid && deq_rank[31] && port_onehot;
      if (deq_valid && deq_rank[31]) begin
        s1_port_reg <= port_idx;
        s1_word_reg <= deq_rank;
        if (!port_onehot) err_port <= 1'b1;
      end
    end
  end

  // Stage 2: per-port epoch compare and commit; read and write share this stage.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
      logic [31:0]      info_reg;
      logic [CNT_W-1:0] deq_cnt_reg;
      logic [CNT_W-1:0] stale_cnt_reg;
      logic             hit;
      logic             accept;

      assign hit = s1_valid_reg && (s1_port_reg == 3'(gi));

`ifdef WRR_LAST_RANK_STALE_FILTER_EN
      logic [12:0] epoch_diff;
      // Modular distance over {overflow, round}; upper half of the circle is treated as older.
      assign epoch_diff = s1_word_reg[24:12] - info_reg[24:12];
      assign accept     = (info_reg == 32'd0) || !epoch_diff[12];
`else
      assign accept = 1'b1;
`endif

      always_ff @(posedge clk_dp) begin
        if (!rst_n) begin
          info_reg      <= 32'd0;
          deq_cnt_reg   <= '0;
          stale_cnt_reg <= '0;
        end else if (hit) begin
          if (accept) begin
            info_reg <= s1_word_reg;
            if (deq_cnt_reg != CNT_MAX) deq_cnt_reg <= deq_cnt_reg + 1'b1;
          end else if (stale_cnt_reg != CNT_MAX) begin
            stale_cnt_reg <= stale_cnt_reg + 1'b1;
          end
        end
      end

      assign info_vec[gi]      = info_reg;
      assign deq_cnt_vec[gi]   = deq_cnt_reg;
      assign stale_cnt_vec[gi] = stale_cnt_reg;
    end
  endgenerate

  assign wire_out_last_pkt_info0 = info_vec[0];
  assign wire_out_last_pkt_info1 = info_vec[1];
  assign wire_out_last_pkt_info2 = info_vec[2];
  assign wire_out_last_pkt_info3 = info_vec[3];
  assign wire_out_last_pkt_info4 = info_vec[4];

  // Out-of-range port indices fall through to zero.
  always_comb begin
    rd_word = 32'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cp_rd_port == 3'(i)) rd_word = {deq_cnt_vec[i], stale_cnt_vec[i]};
    end
  end

  // Samples counters at the request edge, so a same-edge commit is not visible yet.
  always_ff @(posedge clk_dp) begin
    if (!rst_n) begin
      cp_rd_valid_out <= 1'b0;
      cp_rd_data      <= 32'd0;
    end else begin
      cp_rd_valid_out <= cp_rd_valid;
      if (cp_rd_valid) cp_rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_wrr_last_rank_tracker.sv
// Directed, table-driven bench for wrr_last_rank_tracker; expectations follow WRR_LAST_RANK_STALE_FILTER_EN.
module tb_wrr_last_rank_tracker;

`ifdef WRR_LAST_RANK_STALE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk_dp = 1'b0;
  logic        rst_n;
  logic        deq_valid;
  logic [7:0]  deq_port;
  logic [31:0] deq_rank;
  logic [31:0] info0, info1, info2, info3, info4;
  logic        cp_rd_valid;
  logic [2:0]  cp_rd_port;
  logic        cp_rd_valid_out;
  logic [31:0] cp_rd_data;
  logic        err_port;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_dp = ~clk_dp;

  wrr_last_rank_tracker dut (
    .clk_dp(clk_dp), .rst_n(rst_n),
    .deq_valid(deq_valid), .deq_port(deq_port), .deq_rank(deq_rank),
    .wire_out_last_pkt_info0(info0), .wire_out_last_pkt_info1(info1),
    .wire_out_last_pkt_info2(info2), .wire_out_last_pkt_info3(info3),
    .wire_out_last_pkt_info4(info4),
    .cp_rd_valid(cp_rd_valid), .cp_rd_port(cp_rd_port),
    .cp_rd_valid_out(cp_rd_valid_out), .cp_rd_data(cp_rd_data),
    .err_port(err_port)
  );

  typedef struct {
    logic [7:0]  port;
    logic [31:0] rank;
    int          chk;
    logic [31:0] exp_info;
    logic [31:0] exp_cp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] info_of(int p);
    case (p)
      0: return info0;
      1: return info1;
      2: return info2;
      3: return info3;
      default: return info4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic send(input logic [7:0] port, input logic [31:0] rank);
    deq_valid = 1'b1;
    deq_port  = port;
    deq_rank  = rank;
    @(negedge clk_dp);
    deq_valid = 1'b0;
  endtask

  task automatic cp_read(input logic [2:0] port, output logic [31:0] data, output logic vld);
    cp_rd_valid = 1'b1;
    cp_rd_port  = port;
    @(negedge clk_dp);
    cp_rd_valid = 1'b0;
    data = cp_rd_data;
    vld  = cp_rd_valid_out;
  endtask

  initial begin
    logic [31:0] d;
    logic        v;

    vecs[0] = '{8'h01, 32'h8003_1000, 0, 32'h8003_1000, 32'h0001_0000, 1'b0};
    vecs[1] = '{8'h01, 32'h8003_0000, 0,
                FILT ? 32'h8003_1000 : 32'h8003_0000,
                FILT ? 32'h0001_0001 : 32'h0002_0000, 1'b0};
    vecs[2] = '{8'h02, 32'h81FF_F000, 1, 32'h81FF_F000, 32'h0001_0000, 1'b0};
    vecs[3] = '{8'h02, 32'h8000_0000, 1, 32'h8000_0000, 32'h0002_0000, 1'b0};
    vecs[4] = '{8'h03, 32'h8005_5000, 0,
                FILT ? 32'h8003_1000 : 32'h8003_0000,
                FILT ? 32'h0001_0001 : 32'h0002_0000, 1'b1};
    vecs[5] = '{8'h20, 32'h8006_6000, 0,
                FILT ? 32'h8003_1000 : 32'h8003_0000,
                FILT ? 32'h0001_0001 : 32'h0002_0000, 1'b1};
    vecs[6] = '{8'h08, 32'h0007_7000, 3, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{8'h08, 32'h8007_7000, 3, 32'h8007_7000, 32'h0001_0000, 1'b1};

    rst_n = 1'b0; deq_valid = 1'b0; deq_port = 8'd0; deq_rank = 32'd0;
    cp_rd_valid = 1'b0; cp_rd_port = 3'd0;

    // Reset state
    repeat (20) @(negedge clk_dp);
    for (int p = 0; p < 5; p++) check($sformatf("reset info%0d", p), info_of(p), 32'd0);
    check("reset err_port", {31'd0, err_port}, 32'd0);
    check("reset cp_rd_valid_out", {31'd0, cp_rd_valid_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_dp);
    cp_read(3'd0, d, v);
    check("reset cp0 data", d, 32'd0);
    check("reset cp0 valid", {31'd0, v}, 32'd1);

    // Table-driven single events
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].port, vecs[i].rank);
      @(negedge clk_dp);
      check($sformatf("vec%0d info%0d", i, vecs[i].chk), info_of(vecs[i].chk), vecs[i].exp_info);
      check($sformatf("vec%0d err_port", i), {31'd0, err_port}, {31'd0, vecs[i].exp_err});
      cp_read(3'(vecs[i].chk), d, v);
      check($sformatf("vec%0d cp%0d", i, vecs[i].chk), d, vecs[i].exp_cp);
    end

    // Out-of-range CP port
    cp_read(3'd5, d, v);
    check("cp5 data", d, 32'd0);
    check("cp5 valid", {31'd0, v}, 32'd1);

    // Back-to-back events to port 2: newer then older epoch
    deq_valid = 1'b1; deq_port = 8'h04; deq_rank = 32'h8001_1000;
    @(negedge clk_dp);
    deq_rank = 32'h8001_0000;
    @(negedge clk_dp);
    deq_valid = 1'b0;
    @(negedge clk_dp);
    check("b2b info2", info2, FILT ? 32'h8001_1000 : 32'h8001_0000);
    cp_read(3'd2, d, v);
    check("b2b cp2", d, FILT ? 32'h0001_0001 : 32'h0002_0000);

    // CP read on the same edge as a commit sees pre-update counts
    send(8'h08, 32'h8007_8000);
    cp_read(3'd3, d, v);
    check("same-edge cp3", d, 32'h0001_0000);
    check("same-edge info3", info3, 32'h8007_8000);
    cp_read(3'd3, d, v);
    check("after-commit cp3", d, 32'h0002_0000);

    // Saturation on port 4
    deq_valid = 1'b1; deq_port = 8'h10; deq_rank = 32'h8000_0000;
    repeat (65540) @(negedge clk_dp);
    deq_valid = 1'b0;
    @(negedge clk_dp);
    check("sat info4", info4, 32'h8000_0000);
    cp_read(3'd4, d, v);
    check("sat cp4", d, 32'hFFFF_0000);

    // Event in flight when a one-edge reset hits
    send(8'h10, 32'h8000_1000);
    rst_n = 1'b0;
    @(negedge clk_dp);
    rst_n = 1'b1;
    @(negedge clk_dp);
    @(negedge clk_dp);
    check("midrst info4", info4, 32'd0);
    check("midrst info0", info0, 32'd0);
    check("midrst err_port", {31'd0, err_port}, 32'd0);
    cp_read(3'd4, d, v);
    check("midrst cp4", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wrr_last_rank_tracker.md
# wrr_last_rank_tracker

Dequeue-side companion to the WRR rank calculator. Monitors PIFO dequeue events, keeps the most recent dequeued rank word per egress port (ports 0-4), and drives it back to the rank calculator's `wire_in_last_pkt_info0..4` inputs so outaged classes resynchronise to the current round. It also keeps per-port dequeue and stale-event counters, readable by the control plane.

## Interface
- `NUM_PORTS`, 5: tracked ports; fixed at 5, since the output ports are enumerated.
- `CNT_W`, 16: width of each saturating counter.
- `clk_dp`, in, 1: data-plane clock; the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `deq_valid`, in, 1: dequeue event strobe, one event per cycle.
- `deq_port`, in, 8: one-hot egress port bitmap, same encoding as the rank-calc input.
- `deq_rank`, in, 32: dequeued PIFO word {valid[31], rank[30:12], reserved[11:0]}.
  - rank = {unused[30], class[29:25], overflow[24:23], round[22:12]}.
- `wire_out_last_pkt_info0..4`, out, 32 each: last accepted dequeued word per port.
- `cp_rd_valid`, in, 1: control-plane read request.
- `cp_rd_port`, in, 3: port index for the read.
- `cp_rd_valid_out`, out, 1: read response strobe.
- `cp_rd_data`, out, 32: read response, {deq_cnt[31:16], stale_cnt[15:0]}.
- `err_port`, out, 1: sticky; set on any malformed port bitmap.

## Operation
- **Stage 1** (registered) validates and decodes the event.
  - The event is dropped if `deq_rank[31]==0`.
  - If `deq_port` is not one-hot or selects bit ≥5, the event is dropped and `err_port` is set.
  - Otherwise the stage latches the port index, the word, and epoch = {overflow, round} (13 bits).
- **Stage 2** reads the stored epoch of the target port and computes d = (new_epoch − old_epoch) mod 8192.
  - d < 4096 (newer or equal): store the word and increment `deq_cnt`.
  - Otherwise (stale): keep the stored word and increment `stale_cnt`.
- The read and write of the per-port register both happen in stage 2. Back-to-back events to the same port therefore need no forwarding.
- A port that has never been written (stored word 0) accepts its first valid event unconditionally.
- Counters saturate at 0xFFFF; they do not wrap.
- **CP read:** registered with 1-cycle latency. It returns the counter values as they stood at the request edge, i.e. before any same-cycle stage-2 update.
  - `cp_rd_port` ≥5 returns data 0 with `cp_rd_valid_out` still asserted.
- `err_port` is cleared only by reset.

## Timing
- Reset (`rst_n` low at a `clk_dp` edge) clears all of the following to 0:
  - all `wire_out_last_pkt_info*` outputs
  - all counters
  - the pipeline valid bits
  - `err_port`, `cp_rd_valid_out` and `cp_rd_data`
- Reset mid-pipeline discards any in-flight event.
- Latency: an event at edge N updates `wire_out_last_pkt_info*` at edge N+2.
- Throughput: one event per cycle, with no backpressure.
- Events on consecutive cycles to the same port are evaluated in arrival order; the second compares against the first's result.
- A CP read of the same port as a committing update returns the pre-update counts.

## Configuration
- `WRR_LAST_RANK_STALE_FILTER_EN`
  - Defined: the epoch comparison above is active.
  - Undefined: every valid event overwrites the stored word, `deq_cnt` increments, and `stale_cnt` stays 0.

## Test plan
- **Reset:** hold `rst_n`=0 for 20 cycles → all five info outputs are 0x00000000, `err_port`=0, and a CP read of port 0 returns 0x00000000.
- **Normal update:** `deq_port`=0x01, `deq_rank`=0x80031000 (round 49) → `wire_out_last_pkt_info0`=0x80031000 two cycles later; CP read of port 0 → 0x00010000.
- **Stale** (filter enabled): continue with `deq_rank`=0x80030000 (round 48) to port 0 → info0 stays 0x80031000; CP read → 0x00010001.
  - With the filter disabled, the same stimulus gives info0=0x80030000 and CP read 0x00020000.
- **Wrap-around:** port 1 gets 0x81FFF000 (overflow 3, round 2047), then 0x80000000 on the next cycle → `wire_out_last_pkt_info1`=0x80000000, deq_cnt=2, stale_cnt=0.
- **Malformed:** `deq_port`=0x03, then 0x20, each with a valid rank → no output changes and `err_port`=1. A `deq_rank` with bit 31 clear → silently ignored.
- **Saturation and reset mid-pipeline:** 65,540 events to port 4 → deq_cnt=0xFFFF. Then an event followed by `rst_n`=0 on the next edge → info4=0 after reset.
